// File: rtl/bcharger_cmp_sched.sv
// bcharger_cmp_sched: time-shares one comparator across the charger thresholds,
// debouncing the active phase's flag and flagging phase timeouts.
module bcharger_cmp_sched #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEB_COUNT     = 3,
  parameter int INTERVAL      = 8,
  parameter int TIMEOUT_SLOTS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       trkl,
  input  logic       fast,
  input  logic       vconst,
  input  logic       done,
  input  logic       cmp_out,
  output logic       cmp_en,
  output logic [1:0] cmp_sel,
  output logic       vtrkl,
  output logic       vterm,
  output logic       iterm,
  output logic       vrchrg,
  output logic       fault
);
  localparam int CMAX = SETTLE_CYCLES > INTERVAL ? SETTLE_CYCLES : INTERVAL;
  localparam int CW = $clog2(CMAX + 1);
  localparam int DW = $clog2(DEB_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_SLOTS + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WAIT} state_t;
  state_t st_q, st_d;
  logic [3:0] ph_in, ph_q;
  logic [1:0] ch, sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [TW-1:0] slot_q, slot_d;
  logic flag_q, flag_d, fault_q, fault_d;
  logic ph_ok, ph_chg, diff, deb_hit, settle_end, wait_end;
  assign ph_in = {done, vconst, fast, trkl};
  assign ph_ok = $onehot(ph_in);
  assign ph_chg = ph_in != ph_q;
  assign ch = ph_in[3] ? 2'd3 : ph_in[2] ? 2'd2 : ph_in[1] ? 2'd1 : 2'd0;
  assign diff = cmp_out != flag_q;
  assign deb_hit = diff && deb_q == DW'(DEB_COUNT - 1);
  assign settle_end = cnt_q == CW'(SETTLE_CYCLES - 1);
  assign wait_end = cnt_q == CW'(INTERVAL - 1);
  always_comb begin
    st_d = st_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    deb_d = deb_q;
    flag_d = flag_q;
    slot_d = slot_q;
    fault_d = fault_q;
    if (!enable) begin
      st_d = IDLE;
      cnt_d = '0;
      deb_d = '0;
      flag_d = ph_chg ? 1'b0 : flag_q;
      slot_d = ph_chg ? '0 : slot_q;
    end else if (!ph_ok) begin
      st_d = IDLE;
      cnt_d = '0;
      deb_d = '0;
      flag_d = 1'b0;
      slot_d = '0;
      fault_d = 1'b1;
    end else if (ph_chg || st_q == IDLE) begin
      // a phase change aborts the slot in flight, so its sample never lands
      st_d = SETTLE;
      sel_d = ch;
      cnt_d = '0;
      deb_d = '0;
      flag_d = ph_chg ? 1'b0 : flag_q;
      slot_d = ph_chg ? '0 : slot_q;
    end else begin
      case (st_q)
        SETTLE: begin
          st_d = settle_end ? SAMPLE : SETTLE;
          cnt_d = settle_end ? '0 : cnt_q + CW'(1);
        end
        SAMPLE: begin
          st_d = INTERVAL == 0 ? SETTLE : WAIT;
          cnt_d = '0;
          flag_d = deb_hit ? ~flag_q : flag_q;
          deb_d = (!diff || deb_hit) ? '0 : deb_q + DW'(1);
          // the done phase is open-ended, so its slots are never counted
          slot_d = (sel_q == 2'd3 || slot_q == TW'(TIMEOUT_SLOTS)) ? slot_q : slot_q + TW'(1);
          fault_d = fault_q | (slot_d == TW'(TIMEOUT_SLOTS));
        end
        WAIT: begin
          st_d = wait_end ? SETTLE : WAIT;
          cnt_d = wait_end ? '0 : cnt_q + CW'(1);
        end
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      ph_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      deb_q <= '0;
      slot_q <= '0;
      flag_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      st_q <= st_d;
      ph_q <= ph_in;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      deb_q <= deb_d;
      slot_q <= slot_d;
      flag_q <= flag_d;
      fault_q <= fault_d;
    end
  end
  assign cmp_en = st_q == SETTLE || st_q == SAMPLE;
  assign cmp_sel = sel_q;
  assign {vrchrg, iterm, vterm, vtrkl} = flag_q ? 4'b0001 << sel_q : 4'b0000;
  assign fault = fault_q;
endmodule
